// File: rtl/online_div_pkg.sv
// Shared definitions for the online divider digit selector: FSM states,
// datapath step codes, quotient digit encodings and selection thresholds.
package online_div_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_LAST   = 3'd2,
    ST_SELECT = 3'd3,
    ST_EMIT   = 3'd4
  } state_e;

  // Step codes shared by en_shift and enable_d
  localparam logic [1:0] CODE_OFF   = 2'd0;
  localparam logic [1:0] CODE_CHUNK = 2'd1;
  localparam logic [1:0] CODE_UPPER = 2'd2;

  // Quotient digit encoding {plus, minus}
  localparam logic [1:0] DIGIT_POS  = 2'b10;
  localparam logic [1:0] DIGIT_ZERO = 2'b00;
  localparam logic [1:0] DIGIT_NEG  = 2'b01;

  // Estimate thresholds, LSB weight 1/16
  localparam int SEL_POS_TH = 32'sd8;
  localparam int SEL_NEG_TH = -32'sd8;
  localparam int ERR_TH     = 32'sd32;

  // True when a digit encoding is +1 or -1
  function automatic logic digit_nonzero(input logic [1:0] d);
    return d[1] ^ d[0];
  endfunction

endpackage

// File: rtl/online_div_qsel.sv
// Quotient digit selection: forms the signed estimate of the upper residue
// from its signed-digit halves and maps it onto {+1, 0, -1}, flagging
// estimates outside the representable range.
module online_div_qsel
  import online_div_pkg::*;
#(
  parameter int UPPER_BITS = 6
) (
  input  logic [UPPER_BITS-1:0] res_upper_plus,
  input  logic [UPPER_BITS-1:0] res_upper_minus,
  output logic [1:0]            digit,
  output logic                  range_err
);

  localparam int EST_W = UPPER_BITS + 1;
  localparam logic signed [EST_W-1:0] POS_TH  = EST_W'(SEL_POS_TH);
  localparam logic signed [EST_W-1:0] NEG_TH  = EST_W'(SEL_NEG_TH);
  localparam logic signed [EST_W-1:0] ERR_POS = EST_W'(ERR_TH);
  localparam logic signed [EST_W-1:0] ERR_NEG = EST_W'(-ERR_TH);

  logic signed [EST_W-1:0] est_s;

  // Both halves are unsigned magnitudes; one extra bit holds the sign of the difference.
  always_comb begin
    est_s = $signed({1'b0, res_upper_plus}) - $signed({1'b0, res_upper_minus});
  end

  // Digit selection: +1 at or above 8/16, -1 strictly below -8/16.
  always_comb begin
    digit = DIGIT_ZERO;
    if (est_s >= POS_TH) begin
      digit = DIGIT_POS;
    end else if (est_s < NEG_TH) begin
      digit = DIGIT_NEG;
    end else begin
      digit = DIGIT_ZERO;
    end
  end

  // Range check is symmetric in magnitude: -32/16 is already out of range.
  always_comb begin
    range_err = 1'b0;
    if ((est_s >= ERR_POS) || (est_s <= ERR_NEG)) begin
      range_err = 1'b1;
    end else begin
      range_err = 1'b0;
    end
  end

endmodule

// File: rtl/online_div_selector.sv
// Online division controller: sweeps the lower residue chunks through the
// datapath, selects one quotient digit per iteration and hands it out with
// a valid/ready handshake. All outputs are registered and decoded from the
// next state so they line up with the state they describe.
// Optional feature macro: ONLINE_DIV_ERR_CHECK_EN (residue range check with
// sticky error_flag); when undefined error_flag is tied low.
module online_div_selector
  import online_div_pkg::*;
#(
  parameter int UNROLLING  = 4,
  parameter int UPPER_BITS = 6,
  parameter int RAM_width  = 7,
  parameter int NUM_CHUNKS = 8,
  parameter int NUM_DIGITS = 32
) (
  input  logic                  clk,
  input  logic                  async_clear_n,
  input  logic                  start,
  input  logic [UPPER_BITS-1:0] res_upper_plus,
  input  logic [UPPER_BITS-1:0] res_upper_minus,
  input  logic                  q_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  q_valid,
  output logic                  q_plus,
  output logic                  q_minus,
  output logic [1:0]            enable_d,
  output logic [1:0]            en_shift,
  output logic                  enable_cout,
  output logic                  d_neg,
  output logic [RAM_width-1:0]  read_addr,
  output logic [RAM_width-1:0]  write_addr,
  output logic                  error_flag
);

  localparam int unused_unrolling = UNROLLING;
  localparam logic [RAM_width-1:0] LAST_CHUNK = RAM_width'(NUM_CHUNKS - 2);
  localparam logic [7:0]           LAST_DIGIT = 8'(NUM_DIGITS - 1);
  localparam logic [RAM_width-1:0] ADDR_ZERO  = {RAM_width{1'b0}};

  state_e               state_r, state_s;
  logic [RAM_width-1:0] chunk_r, chunk_s;
  logic [7:0]           digit_cnt_r, digit_cnt_s;
  logic [1:0]           q_prev_r, q_prev_s;
  logic [1:0]           hold_r, hold_s;
  logic                 done_s, err_set_s, err_clr_s;
  logic [1:0]           qsel_digit_s;
  logic                 range_err_s, err_abort_s;

  logic                 busy_s, q_valid_s, q_plus_s, q_minus_s;
  logic [1:0]           en_shift_s, enable_d_s;
  logic                 enable_cout_s, d_neg_s;
  logic [RAM_width-1:0] read_addr_s, write_addr_s;

  online_div_qsel #(.UPPER_BITS(UPPER_BITS)) u_qsel (
    .res_upper_plus (res_upper_plus),
    .res_upper_minus(res_upper_minus),
    .digit          (qsel_digit_s),
    .range_err      (range_err_s)
  );

`ifdef ONLINE_DIV_ERR_CHECK_EN
  // Out-of-range estimate aborts the division.
  always_comb begin
    err_abort_s = range_err_s;
  end
`else
  // No range check: the selector result is always used.
  always_comb begin
    err_abort_s = 1'b0;
  end
`endif

  // Next-state, counter and digit bookkeeping.
  always_comb begin
    state_s     = state_r;
    chunk_s     = chunk_r;
    digit_cnt_s = digit_cnt_r;
    q_prev_s    = q_prev_r;
    hold_s      = hold_r;
    done_s      = 1'b0;
    err_set_s   = 1'b0;
    err_clr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_SWEEP;
          chunk_s     = ADDR_ZERO;
          digit_cnt_s = 8'd0;
          q_prev_s    = DIGIT_ZERO;
          err_clr_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (chunk_r == LAST_CHUNK) begin
          state_s = ST_LAST;
          chunk_s = ADDR_ZERO;
        end else begin
          chunk_s = chunk_r + RAM_width'(1);
        end
      end
      ST_LAST: begin
        state_s = ST_SELECT;
      end
      ST_SELECT: begin
        hold_s = qsel_digit_s;
        if (err_abort_s) begin
          state_s   = ST_IDLE;
          done_s    = 1'b1;
          err_set_s = 1'b1;
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (q_ready) begin
          q_prev_s = hold_r;
          chunk_s  = ADDR_ZERO;
          if (digit_cnt_r == LAST_DIGIT) begin
            state_s     = ST_IDLE;
            done_s      = 1'b1;
            digit_cnt_s = 8'd0;
          end else begin
            state_s     = ST_SWEEP;
            digit_cnt_s = digit_cnt_r + 8'd1;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Decode the output values for the cycle after the next clock edge.
  always_comb begin
    busy_s        = 1'b1;
    q_valid_s     = 1'b0;
    q_plus_s      = 1'b0;
    q_minus_s     = 1'b0;
    en_shift_s    = CODE_OFF;
    enable_cout_s = 1'b0;
    read_addr_s   = ADDR_ZERO;
    write_addr_s  = ADDR_ZERO;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_SWEEP: begin
        en_shift_s    = CODE_CHUNK;
        enable_cout_s = (chunk_s != ADDR_ZERO);
        read_addr_s   = chunk_s;
        write_addr_s  = read_addr;
      end
      ST_LAST: begin
        en_shift_s    = CODE_UPPER;
        enable_cout_s = 1'b1;
        write_addr_s  = read_addr;
      end
      ST_SELECT: begin
        busy_s = 1'b1;
      end
      ST_EMIT: begin
        q_valid_s = 1'b1;
        q_plus_s  = (hold_s == DIGIT_POS);
        q_minus_s = (hold_s == DIGIT_NEG);
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
    enable_d_s = digit_nonzero(q_prev_s) ? en_shift_s : CODE_OFF;
    d_neg_s    = busy_s && (q_prev_s == DIGIT_POS);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      state_r     <= ST_IDLE;
      chunk_r     <= ADDR_ZERO;
      digit_cnt_r <= 8'd0;
      q_prev_r    <= DIGIT_ZERO;
      hold_r      <= DIGIT_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      q_valid     <= 1'b0;
      q_plus      <= 1'b0;
      q_minus     <= 1'b0;
      en_shift    <= CODE_OFF;
      enable_d    <= CODE_OFF;
      enable_cout <= 1'b0;
      d_neg       <= 1'b0;
      read_addr   <= ADDR_ZERO;
      write_addr  <= ADDR_ZERO;
    end else begin
      state_r     <= state_s;
      chunk_r     <= chunk_s;
      digit_cnt_r <= digit_cnt_s;
      q_prev_r    <= q_prev_s;
      hold_r      <= hold_s;
      busy        <= busy_s;
      done        <= done_s;
      q_valid     <= q_valid_s;
      q_plus      <= q_plus_s;
      q_minus     <= q_minus_s;
      en_shift    <= en_shift_s;
      enable_d    <= enable_d_s;
      enable_cout <= enable_cout_s;
      d_neg       <= d_neg_s;
      read_addr   <= read_addr_s;
      write_addr  <= write_addr_s;
    end
  end

`ifdef ONLINE_DIV_ERR_CHECK_EN
  // Sticky range error: cleared by a new division, set by an aborted one.
  always_ff @(posedge clk or negedge async_clear_n) begin
    if (!async_clear_n) begin
      error_flag <= 1'b0;
    end else if (err_clr_s) begin
      error_flag <= 1'b0;
    end else if (err_set_s) begin
      error_flag <= 1'b1;
    end else begin
      error_flag <= error_flag;
    end
  end
`else
  logic unused_err_s;
  assign unused_err_s = err_set_s ^ err_clr_s ^ range_err_s;
  assign error_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_online_div_selector.sv
// Self-checking bench for online_div_selector (NUM_CHUNKS=8, NUM_DIGITS=4).
module tb_online_div_selector;

  localparam int NC = 8;
  localparam int ND = 4;
  localparam int UB = 6;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          async_clear_n = 1'b0;
  logic          start = 1'b0;
  logic          q_ready = 1'b1;
  logic [UB-1:0] res_upper_plus = '0;
  logic [UB-1:0] res_upper_minus = '0;
  logic          busy, done, q_valid, q_plus, q_minus, enable_cout, d_neg, error_flag;
  logic [1:0]    enable_d, en_shift;
  logic [AW-1:0] read_addr, write_addr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int m_qprev = 0;    // previously accepted digit as -1/0/+1
  int m_dcount = 0;   // digits accepted in the current division

  online_div_selector #(
    .UNROLLING(4), .UPPER_BITS(UB), .RAM_width(AW), .NUM_CHUNKS(NC), .NUM_DIGITS(ND)
  ) dut (
    .clk(clk), .async_clear_n(async_clear_n), .start(start),
    .res_upper_plus(res_upper_plus), .res_upper_minus(res_upper_minus),
    .q_ready(q_ready), .busy(busy), .done(done), .q_valid(q_valid),
    .q_plus(q_plus), .q_minus(q_minus), .enable_d(enable_d), .en_shift(en_shift),
    .enable_cout(enable_cout), .d_neg(d_neg), .read_addr(read_addr),
    .write_addr(write_addr), .error_flag(error_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference digit selection from the arithmetic estimate (units of 1/16)
  function automatic int ref_digit(int p, int m);
    int est;
    est = p - m;
    if (est >= 8) return 1;
    else if (est < -8) return -1;
    else return 0;
  endfunction

  function automatic logic [1:0] ref_code(int d);
    return (d == 1) ? 2'b10 : ((d == -1) ? 2'b01 : 2'b00);
  endfunction

  task automatic start_div();
    @(negedge clk);
    start = 1'b1;
    m_qprev = 0;
    m_dcount = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one iteration starting at the first SWEEP cycle; ends at the negedge after it.
  task automatic run_iteration(input int p, input int m, input int stall,
                               input bit poke_start, input bit expect_err);
    int d;
    logic [1:0]  sh;
    logic [23:0] obs, exp;
    logic [21:0] obs2;
    logic [23:0] obs3, exp3;
    res_upper_plus  = p[UB-1:0];
    res_upper_minus = m[UB-1:0];
    d = ref_digit(p, m);
    for (int i = 0; i < NC; i++) begin
      sh  = (i < NC - 1) ? 2'd1 : 2'd2;
      exp = {1'b1, 1'b0, 1'b0, 1'b0, sh, (m_qprev != 0) ? sh : 2'd0, (i != 0), (m_qprev == 1),
             (i < NC - 1) ? AW'(i) : AW'(0), (i == 0) ? AW'(0) : AW'(i - 1)};
      obs = {busy, q_valid, done, error_flag, en_shift, enable_d, enable_cout, d_neg,
             read_addr, write_addr};
      total_cnt++;
      if (obs !== exp) $display("FAIL sweep[%0d] digit %0d: got %h expected %h", i, m_dcount, obs, exp);
      else pass_cnt++;
      start = poke_start && (i == 2);
      @(negedge clk);
    end
    start = 1'b0;
    obs2 = {busy, q_valid, done, en_shift, enable_d, enable_cout, read_addr, write_addr};
    total_cnt++;
    if (obs2 !== {1'b1, 21'd0}) $display("FAIL select digit %0d: got %h expected %h", m_dcount, obs2, {1'b1, 21'd0});
    else pass_cnt++;
    @(negedge clk);
    if (expect_err) begin
      total_cnt++;
      if ({busy, q_valid, done, error_flag, en_shift, enable_d} !== 8'b0011_0000)
        $display("FAIL range_abort: got %b expected 00110000", {busy, q_valid, done, error_flag, en_shift, enable_d});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({busy, q_valid, done, error_flag} !== 4'b0001)
        $display("FAIL range_sticky: got %b expected 0001", {busy, q_valid, done, error_flag});
      else pass_cnt++;
    end else begin
      for (int s = 0; s <= stall; s++) begin
        obs3 = {busy, q_valid, done, q_plus, q_minus, en_shift, enable_d, enable_cout, d_neg & 1'b0,
                read_addr, write_addr};
        exp3 = {1'b1, 1'b1, 1'b0, ref_code(d), 2'd0, 2'd0, 1'b0, 1'b0, AW'(0), AW'(0)};
        total_cnt++;
        if (obs3 !== exp3) $display("FAIL emit[%0d] digit %0d: got %h expected %h", s, m_dcount, obs3, exp3);
        else pass_cnt++;
        q_ready = (s == stall);
        @(negedge clk);
      end
      m_qprev = d;
      m_dcount++;
      if (m_dcount == ND) begin
        total_cnt++;
        if ({busy, q_valid, done, en_shift, enable_d, enable_cout} !== 8'b0010_0000)
          $display("FAIL done_pulse: got %b expected 00100000", {busy, q_valid, done, en_shift, enable_d, enable_cout});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, done, q_valid} !== 3'b000) $display("FAIL done_single: got %b expected 000", {busy, done, q_valid});
        else pass_cnt++;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [25:0] obs;
    obs = {busy, done, q_valid, q_plus, q_minus, enable_d, en_shift, enable_cout, d_neg,
           read_addr, write_addr, error_flag};
    total_cnt++;
    if (obs !== 26'd0) $display("FAIL %s: got %h expected 0", name, obs);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    async_clear_n = 1'b0;
    start = 1'b1;
    res_upper_plus = 6'h3F;
    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    start = 1'b0;
    async_clear_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_latency();
    int cnt;
    res_upper_plus = 6'd0;
    res_upper_minus = 6'd0;
    @(negedge clk);
    start = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
      if (q_valid) break;
    end
    total_cnt++;
    if (cnt !== 10 || q_valid !== 1'b1) $display("FAIL first_qvalid_latency: got %0d cycles (q_valid=%b) expected 10", cnt, q_valid);
    else pass_cnt++;
    #2 async_clear_n = 1'b0;
    #1 check_all_zero("reset_in_emit");
    @(negedge clk);
    async_clear_n = 1'b1;
  endtask

  task automatic test_digit_select();
    start_div();
    run_iteration(10, 0, 0, 0, 0);
    run_iteration(0, 10, 0, 0, 0);
    run_iteration(8, 1, 0, 0, 0);
    run_iteration(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), 0, 0, 0);
    start_div();
    run_iteration(8, 0, 0, 0, 0);
    run_iteration(0, 8, 0, 0, 0);
    run_iteration(0, 9, 0, 0, 0);
    run_iteration(7, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    start_div();
    run_iteration(12, 1, 5, 0, 0);
    run_iteration(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), 0, 1, 0);
    run_iteration(2, 20, 2, 0, 0);
    run_iteration(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), 5, 0, 0);
  endtask

  task automatic test_reset_mid();
    start_div();
    repeat (3) @(negedge clk);
    #2 async_clear_n = 1'b0;
    #1 check_all_zero("reset_mid_sweep");
    @(negedge clk);
    async_clear_n = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_mid_reset");
    start_div();
    for (int k = 0; k < ND; k++)
      run_iteration(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), 0, 0, 0);
  endtask

  task automatic test_range();
`ifdef ONLINE_DIV_ERR_CHECK_EN
    start_div();
    run_iteration(31, 63, 0, 0, 1);
    start_div();
    for (int k = 0; k < ND; k++)
      run_iteration(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), 0, 0, 0);
`else
    start_div();
    run_iteration(31, 63, 0, 0, 0);
    for (int k = 1; k < ND; k++)
      run_iteration(int'($urandom_range(63, 0)), int'($urandom_range(63, 0)), 0, 0, 0);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      start_div();
      for (int k = 0; k < ND; k++)
        run_iteration(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
                      int'($urandom_range(2, 0)), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_digit_select();
    test_stall();
    test_reset_mid();
    test_range();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
